// File: rtl/waveform_pkg.sv
// Shared codes for the e-ink waveform sequencer: phase-type values, FSM state encoding, phase width.
package waveform_pkg;
  localparam int PHASE_W = 7;

  localparam logic [1:0] PT_INIT = 2'b00;
  localparam logic [1:0] PT_GC4  = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SETTLE,
    ST_STREAM,
    ST_DRAIN,
    ST_LGAP,
    ST_FGAP,
    ST_DONE
  } state_t;
endpackage

// File: rtl/waveform_sequencer_if.sv
// Host command, framebuffer, waveform LUT and source-driver signals of one panel update.
interface waveform_sequencer_if #(parameter int ADDR_W = 17);
  import waveform_pkg::*;

  logic               start;
  logic [1:0]         type_in;
  logic               busy;
  logic               done;
  logic [PHASE_W-1:0] phase;
  logic [1:0]         phase_type;
  logic [PHASE_W-1:0] phase_count;
  logic               fb_rd_en;
  logic [ADDR_W-1:0]  fb_addr;
  logic [15:0]        fb_rd_data;
  logic [15:0]        lut_data_in;
  logic [7:0]         lut_data_out;
  logic [7:0]         src_data;
  logic               src_valid;
  logic               src_ready;
  logic               frame_start;
  logic               line_start;

  modport master (
    input  start, type_in, phase_count, fb_rd_data, lut_data_out, src_ready,
    output busy, done, phase, phase_type, fb_rd_en, fb_addr, lut_data_in,
           src_data, src_valid, frame_start, line_start
  );

  modport slave (
    output start, type_in, phase_count, fb_rd_data, lut_data_out, src_ready,
    input  busy, done, phase, phase_type, fb_rd_en, fb_addr, lut_data_in,
           src_data, src_valid, frame_start, line_start
  );
endinterface

// File: rtl/src_fifo2.sv
// Two-entry valid/ready byte FIFO with occupancy output; head is registered, push-to-head latency 1 cycle.
module src_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push_vld,
  input  logic [W-1:0] i_push_dat,
  output logic         o_pop_vld,
  output logic [W-1:0] o_pop_dat,
  input  logic         i_pop_rdy,
  output logic [1:0]   o_occ
);
  logic [W-1:0] r_mem [2];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_occ;
  logic         w_push;
  logic         w_pop;

  assign w_push = i_push_vld && (r_occ != 2'd2);
  assign w_pop  = (r_occ != 2'd0) && i_pop_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_push_dat;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign o_pop_vld = (r_occ != 2'd0);
  assign o_pop_dat = r_mem[r_rptr];
  assign o_occ     = r_occ;
endmodule

// File: rtl/waveform_sequencer.sv
// Walks every phase of an e-ink update, scanning the framebuffer through the LUT into the source driver.
// Reads are credit-limited to two outstanding bytes, so a stalled src_ready stalls reads without loss.
module waveform_sequencer #(
  parameter int H_WORDS   = 200,
  parameter int V_LINES   = 600,
  parameter int ADDR_W    = 17,
  parameter int SETTLE    = 2,
  parameter int LINE_GAP  = 4,
  parameter int FRAME_GAP = 16
) (
  input logic clk,
  input logic rst_n,
  waveform_sequencer_if.master bus
);
  import waveform_pkg::*;

  localparam int CNT_W  = 16;
  localparam int WORD_W = $clog2(H_WORDS + 1);
  localparam int LINE_W = $clog2(V_LINES + 1);

  state_t             r_state;
  logic               r_busy;
  logic               r_done;
  logic [PHASE_W-1:0] r_phase;
  logic [1:0]         r_phase_type;
  logic [PHASE_W-1:0] r_count;
  logic [CNT_W-1:0]   r_cnt;
  logic [WORD_W-1:0]  r_word;
  logic [LINE_W-1:0]  r_line;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_inflight;
  logic               r_frame_start;
  logic               r_line_start;

  logic               w_src_vld;
  logic [1:0]         w_occ;
  logic               w_pop;
  logic [2:0]         w_outstanding;
  logic               w_issue;

  // A byte leaving the FIFO this cycle frees its slot for a read issued now.
  assign w_pop         = w_src_vld && bus.src_ready;
  assign w_outstanding = {1'b0, w_occ} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_issue       = (r_state == ST_STREAM) && (w_outstanding < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_phase       <= '0;
      r_phase_type  <= '0;
      r_count       <= '0;
      r_cnt         <= '0;
      r_word        <= '0;
      r_line        <= '0;
      r_addr        <= '0;
      r_inflight    <= 1'b0;
      r_frame_start <= 1'b0;
      r_line_start  <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      r_line_start  <= 1'b0;
      r_done        <= 1'b0;
      r_inflight    <= w_issue;
      case (r_state)
        ST_IDLE: if (bus.start) begin
          r_phase_type <= bus.type_in;
          r_phase      <= '0;
          r_busy       <= 1'b1;
          r_state      <= ST_SETUP;
        end
        ST_SETUP: begin
          r_count <= bus.phase_count;
          if (bus.phase_count == '0) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_SETTLE;
            r_cnt   <= CNT_W'(SETTLE - 1);
            if (SETTLE == 1) begin
              r_frame_start <= 1'b1;
              r_line_start  <= 1'b1;
            end
          end
        end
        // Strobes are registered, so they are raised one cycle ahead of the last SETTLE cycle.
        ST_SETTLE: if (r_cnt == '0) begin
          r_state <= ST_STREAM;
          r_addr  <= '0;
          r_line  <= '0;
          r_word  <= '0;
        end else begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            r_frame_start <= 1'b1;
            r_line_start  <= 1'b1;
          end
        end
        ST_STREAM: if (w_issue) begin
          if (r_word == WORD_W'(H_WORDS - 1)) begin
            r_state <= ST_DRAIN;
          end else begin
            r_word <= r_word + 1'b1;
            r_addr <= r_addr + 1'b1;
          end
        end
        ST_DRAIN: if ((w_occ == 2'd0) && !r_inflight) begin
          if (r_line != LINE_W'(V_LINES - 1)) begin
            r_state <= ST_LGAP;
            r_cnt   <= CNT_W'(LINE_GAP - 1);
            if (LINE_GAP == 1) r_line_start <= 1'b1;
          end else if (r_phase != r_count - 1'b1) begin
            r_state <= ST_FGAP;
            r_phase <= r_phase + 1'b1;
            r_cnt   <= CNT_W'(FRAME_GAP);
          end else begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_LGAP: if (r_cnt == '0) begin
          r_state <= ST_STREAM;
          r_line  <= r_line + 1'b1;
          r_word  <= '0;
          r_addr  <= r_addr + 1'b1;
        end else begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) r_line_start <= 1'b1;
        end
        ST_FGAP: if (r_cnt == '0) begin
          r_state <= ST_SETTLE;
          r_cnt   <= CNT_W'(SETTLE - 1);
          if (SETTLE == 1) begin
            r_frame_start <= 1'b1;
            r_line_start  <= 1'b1;
          end
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  src_fifo2 #(.W(8)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push_vld (r_inflight),
    .i_push_dat (bus.lut_data_out),
    .o_pop_vld  (w_src_vld),
    .o_pop_dat  (bus.src_data),
    .i_pop_rdy  (bus.src_ready),
    .o_occ      (w_occ)
  );

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.phase       = r_phase;
  assign bus.phase_type  = r_phase_type;
  assign bus.fb_rd_en    = w_issue;
  assign bus.fb_addr     = r_addr;
  assign bus.lut_data_in = bus.fb_rd_data;
  assign bus.src_valid   = w_src_vld;
  assign bus.frame_start = r_frame_start;
  assign bus.line_start  = r_line_start;
endmodule

// File: tb/tb_waveform_sequencer.sv
// Directed bench for waveform_sequencer with a byte/read scoreboard and a small LUT/framebuffer model.
module tb_waveform_sequencer;
  import waveform_pkg::*;

  localparam int H = 4;
  localparam int V = 2;
  localparam int AW = 17;
  localparam int ST = 2;
  localparam int LG = 4;
  localparam int FG = 16;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [6:0]    ph;
  } rd_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  waveform_sequencer_if #(.ADDR_W(AW)) bus ();

  waveform_sequencer #(.H_WORDS(H), .V_LINES(V), .ADDR_W(AW), .SETTLE(ST),
                       .LINE_GAP(LG), .FRAME_GAP(FG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_rd = 0, n_acc = 0, n_done = 0, n_busy = 0, max_out = 0;
  logic [7:0] byte_q[$];
  rd_t        rdx_q[$];
  int fs_q[$], ls_q[$], rd_q[$], acc_q[$], ph_q[$];
  logic [6:0] prev_phase = '0;
  logic       rd_smp = 1'b0;
  logic [AW-1:0] rd_adr = '0;

  function automatic logic [15:0] fb_word(input logic [AW-1:0] a);
    logic [7:0] lo;
    lo = a[7:0];
    return {lo ^ 8'hC3, lo * 8'd37 + 8'd11};
  endfunction

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int count);
    logic [15:0] w;
    rd_t r;
    for (int ph = 0; ph < count; ph++) begin
      for (int a = 0; a < H * V; a++) begin
        w = fb_word(AW'(a));
        byte_q.push_back(w[7:0] ^ {7'(ph), 1'b0});
        r.addr = AW'(a);
        r.ph   = 7'(ph);
        rdx_q.push_back(r);
      end
    end
  endtask

  // Framebuffer (1-cycle read latency) and LUT models.
  always @(posedge clk) begin
    rd_smp <= bus.fb_rd_en;
    rd_adr <= bus.fb_addr;
    if (bus.fb_rd_en) bus.fb_rd_data <= fb_word(bus.fb_addr);
  end
  assign bus.lut_data_out = bus.lut_data_in[7:0] ^ {bus.phase, 1'b0};

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    rd_t e;
    int outst;
    outst = n_rd - n_acc;
    if (outst > max_out) max_out = outst;
    if (rd_smp) chk("lut_in", 32'(bus.lut_data_in), 32'(fb_word(rd_adr)));
    if (bus.fb_rd_en) begin
      chk("rd_expected", 32'(rdx_q.size() != 0), 32'd1);
      if (rdx_q.size() != 0) begin
        e = rdx_q.pop_front();
        chk("fb_addr", 32'(bus.fb_addr), 32'(e.addr));
        chk("rd_phase", 32'(bus.phase), 32'(e.ph));
      end
      rd_q.push_back(cyc);
      n_rd++;
    end
    if (bus.src_valid && bus.src_ready) begin
      chk("byte_expected", 32'(byte_q.size() != 0), 32'd1);
      if (byte_q.size() != 0) chk("src_data", 32'(bus.src_data), 32'(byte_q.pop_front()));
      acc_q.push_back(cyc);
      n_acc++;
    end
    if (bus.frame_start) fs_q.push_back(cyc);
    if (bus.line_start) ls_q.push_back(cyc);
    if (bus.done) n_done++;
    if (bus.busy) n_busy++;
    if (bus.busy && bus.phase == prev_phase + 7'd1) ph_q.push_back(cyc);
    prev_phase = bus.phase;
  end

  task automatic run_update(input logic [1:0] t, input logic [6:0] cnt, input bit rnd,
                            input int inj, input int budget, output bit got);
    got = 1'b0;
    bus.type_in     = t;
    bus.phase_count = cnt;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      bus.start = (i == 0) || (i == inj);
      if (i == inj) bus.type_in = 2'b10;
      bus.src_ready = rnd ? ($urandom_range(0, 99) >= 30) : 1'b1;
      @(negedge clk);
      if (bus.done) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.src_ready = 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_phase"}, 32'(bus.phase), 32'd0);
    chk({tag, "_ptype"}, 32'(bus.phase_type), 32'd0);
    chk({tag, "_rd_en"}, 32'(bus.fb_rd_en), 32'd0);
    chk({tag, "_addr"}, 32'(bus.fb_addr), 32'd0);
    chk({tag, "_src_valid"}, 32'(bus.src_valid), 32'd0);
    chk({tag, "_frame_start"}, 32'(bus.frame_start), 32'd0);
    chk({tag, "_line_start"}, 32'(bus.line_start), 32'd0);
  endtask

  initial begin
    bit got;
    int d0, r0, a0, b0;
    bus.start = 1'b0;
    bus.type_in = PT_INIT;
    bus.phase_count = '0;
    bus.src_ready = 1'b1;
    bus.fb_rd_data = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Three init phases, src_ready held high, with timing checks
    fs_q.delete(); ls_q.delete(); rd_q.delete(); acc_q.delete(); ph_q.delete();
    d0 = n_done; a0 = n_acc;
    push_exp(3);
    run_update(PT_INIT, 7'd3, 1'b0, -1, 2000, got);
    chk("s1_done_seen", 32'(got), 32'd1);
    @(negedge clk);
    chk("s1_busy_after", 32'(bus.busy), 32'd0);
    chk("s1_done_count", 32'(n_done - d0), 32'd1);
    chk("s1_bytes", 32'(n_acc - a0), 32'd24);
    chk("s1_bytes_left", 32'(byte_q.size()), 32'd0);
    chk("s1_reads_left", 32'(rdx_q.size()), 32'd0);
    chk("s1_frame_starts", 32'(fs_q.size()), 32'd3);
    chk("s1_line_starts", 32'(ls_q.size()), 32'd6);
    chk("s1_rd_after_fs0", 32'(qat(rd_q, 0) - qat(fs_q, 0)), 32'd1);
    chk("s1_rd_after_fs1", 32'(qat(rd_q, 8) - qat(fs_q, 1)), 32'd1);
    chk("s1_line_gap", 32'(qat(ls_q, 1) - qat(acc_q, 3) - 1), 32'(LG));
    chk("s1_frame_gap", 32'(qat(rd_q, 8) - qat(ph_q, 0)), 32'(FG + 1 + ST));

    // Zero phase count
    d0 = n_done; r0 = n_rd; b0 = n_busy;
    run_update(PT_GC4, 7'd0, 1'b0, -1, 50, got);
    chk("s2_done_seen", 32'(got), 32'd1);
    @(negedge clk);
    chk("s2_busy_cycles", 32'(n_busy - b0), 32'd2);
    chk("s2_no_reads", 32'(n_rd - r0), 32'd0);
    chk("s2_done_count", 32'(n_done - d0), 32'd1);

    // Random 30% backpressure, same byte stream as the first update
    max_out = 0;
    d0 = n_done; a0 = n_acc;
    push_exp(3);
    run_update(PT_INIT, 7'd3, 1'b1, -1, 4000, got);
    chk("s3_done_seen", 32'(got), 32'd1);
    chk("s3_done_count", 32'(n_done - d0), 32'd1);
    chk("s3_bytes", 32'(n_acc - a0), 32'd24);
    chk("s3_bytes_left", 32'(byte_q.size()), 32'd0);
    chk("s3_max_outstanding_le2", 32'(max_out <= 2), 32'd1);

    // Second start pulsed mid-stream is ignored
    d0 = n_done; r0 = n_rd;
    push_exp(2);
    run_update(PT_INIT, 7'd2, 1'b0, 10, 2000, got);
    chk("s4_done_seen", 32'(got), 32'd1);
    chk("s4_done_count", 32'(n_done - d0), 32'd1);
    chk("s4_reads", 32'(n_rd - r0), 32'd16);
    chk("s4_ptype_kept", 32'(bus.phase_type), 32'(PT_INIT));
    chk("s4_bytes_left", 32'(byte_q.size()), 32'd0);

    // Asynchronous reset during the second frame
    d0 = n_done;
    push_exp(3);
    bus.type_in = PT_GC4;
    bus.phase_count = 7'd3;
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus.phase == 7'd1 && bus.src_valid) begin
        got = 1'b1;
        break;
      end
    end
    chk("s5_reached_frame1", 32'(got), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("async_rst");
    repeat (3) @(posedge clk);
    #1;
    byte_q.delete();
    rdx_q.delete();
    @(negedge clk);
    chk("s5_no_done", 32'(n_done - d0), 32'd0);
    chk("s5_busy_in_reset", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clean restart after the abort
    d0 = n_done;
    push_exp(2);
    run_update(PT_GC4, 7'd2, 1'b0, -1, 2000, got);
    chk("s6_done_seen", 32'(got), 32'd1);
    chk("s6_done_count", 32'(n_done - d0), 32'd1);
    chk("s6_ptype", 32'(bus.phase_type), 32'(PT_GC4));
    chk("s6_bytes_left", 32'(byte_q.size()), 32'd0);
    chk("s6_reads_left", 32'(rdx_q.size()), 32'd0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end
endmodule
